instr_mem_model: RTL and testbench
==================================

# instr_mem_model

Parametrised instruction-memory model for CPU simulation benches. It replaces a fixed-word combinational stub with a preloadable word array, a request/ready fetch handshake with configurable wait states, and an out-of-range fill word. It also provides a fetch counter and sticky halt and misalignment flags, so benches can end runs and check progress without probing CPU internals. It sits between the CPU fetch port and the bench top; memory contents survive reset.

## Interface
Parameters:
- DEPTH_LOG2, 10: array holds 2^DEPTH_LOG2 32-bit words
- BASE_ADDR, 32'h0000_0000: byte address of word 0
- WAIT_CYCLES, 0: extra cycles between request acceptance and ready (0..255)
- FILL_WORD, 32'h2421_0001: word returned for out-of-range addresses (ADDIU $1,$1,1)
- HALT_WORD, 32'h1000_FFFF: self-branch instruction used for halt detection

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- req  in  1  fetch request; held high until ready
- addr  in  32  fetch byte address; sampled when a request is accepted
- data  out  32  fetched word; valid only while ready=1
- ready  out  1  one-cycle pulse marking data valid
- ld_en  in  1  preload write enable
- ld_addr  in  32  preload byte address
- ld_data  in  32  preload word
- fetch_count  out  32  completed fetches; saturates at 32'hFFFF_FFFF
- halted  out  1  sticky; set when HALT_WORD is fetched twice in a row from the same address
- misaligned  out  1  sticky; set when a fetch is accepted with addr[1:0]!=0

## Operation
- Word index: idx = (addr - BASE_ADDR) >> 2.
  - In range iff addr >= BASE_ADDR and idx < 2^DEPTH_LOG2.
  - The subtraction is 32-bit unsigned; addr < BASE_ADDR is out of range.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if req=1, latch addr and go to WAIT with counter=WAIT_CYCLES. If WAIT_CYCLES=0, go directly to RESP.
  - WAIT: decrement the counter each cycle. When it reaches 0, go to RESP.
  - RESP lasts one cycle: ready=1, data=the registered word, then return to IDLE.
  - req sampled in RESP is ignored. A still-high req is accepted in the following IDLE cycle.
- Read value:
  - The word is read into the data register on the edge that enters RESP.
  - Returns mem[idx] if in range, otherwise FILL_WORD.
  - Misaligned addresses use addr with bits [1:0] forced to 0 and set misaligned.
- Preload:
  - ld_en=1 writes ld_data to mem[idx(ld_addr)] on the edge if in range. Out-of-range writes are dropped.
  - ld_addr[1:0] are ignored.
  - Preload is accepted in every state, including during reset.
  - A write and a read to the same word on the same edge: the read returns the old word.
- Memory is never cleared by rst. Before its first write, a word reads as FILL_WORD; the model keeps per-word valid bits, which are not cleared by reset.
- fetch_count increments on every ready pulse and stops at all-ones.
- Halt detect:
  - Track the last returned word and its aligned address.
  - halted sets on a ready pulse whose data==HALT_WORD and whose address equals the previous fetch's address, when that previous fetch also returned HALT_WORD.
  - halted stays set until rst; fetches continue normally.

## Timing
- Reset values: state=IDLE, ready=0, data=0, fetch_count=0, halted=0, misaligned=0; last-fetch tracking is cleared.
- rst during WAIT or RESP aborts the access; no ready pulse occurs. The next req is accepted on the first cycle after rst deasserts.
- Latency: req sampled high at edge k (in IDLE) gives ready=1 during cycle k+1+WAIT_CYCLES.
- Throughput: one fetch per WAIT_CYCLES+2 cycles with req held continuously.
- ready is never high for two consecutive cycles.
- data holds its value after ready drops until the next RESP entry.

## Test plan
- Reset then hold req=1 with addr=0 and unloaded memory, WAIT_CYCLES=0: ready pulses every 2nd cycle with data=32'h2421_0001; fetch_count=3 after 6 cycles.
- Preload word 4 (ld_addr=0x10) with 0xDEADBEEF, WAIT_CYCLES=3, fetch addr 0x10: ready appears exactly 4 cycles after acceptance with data=0xDEADBEEF.
- BASE_ADDR=0x8000_0000, fetch 0x7FFF_FFFC and 0x8000_1000 with DEPTH_LOG2=10: both return FILL_WORD. Fetch 0x8000_0FFC returns the preloaded last word.
- Fetch addr=0x13: returns the word at 0x10 and misaligned=1; misaligned stays set over later aligned fetches until rst.
- Preload 0x1000_FFFF at 0x20 and fetch 0x20 twice: halted=0 after the first ready and 1 after the second. Fetching 0x24 in between keeps halted=0.
- Assert rst for one cycle during WAIT (WAIT_CYCLES=5): no ready pulse, fetch_count=0. Preloaded contents are still returned by the next fetch.

Source files
------------

// File: rtl/instr_mem_model.sv
// Instruction-memory model for CPU benches: a preloadable word array behind a
// req/ready fetch handshake, plus a fetch counter and sticky halt/misalignment flags.
module instr_mem_model #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] FILL_WORD   = 32'h2421_0001,
  parameter logic [31:0] HALT_WORD   = 32'h1000_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  output logic [31:0] data,
  output logic        ready,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] fetch_count,
  output logic        halted,
  output logic        misaligned
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [7:0]  WAIT_INIT = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> (DEPTH_LOG2 + 2)) == 32'd0);
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
    return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
  endfunction

  state_t                state_r;
  state_t                state_nxt_s;
  logic [7:0]            wait_cnt_r;
  logic [7:0]            wait_cnt_nxt_s;
  logic                  accept_s;
  logic                  enter_resp_s;
  logic [31:0]           addr_r;
  logic [31:0]           data_r;
  logic                  ready_r;
  logic [31:0]           fetch_count_r;
  logic                  halted_r;
  logic                  misaligned_r;
  logic                  last_valid_r;
  logic [31:0]           last_addr_r;
  logic [31:0]           last_word_r;
  logic [31:0]           rd_addr_s;
  logic [DEPTH_LOG2-1:0] rd_idx_s;
  logic [31:0]           rd_word_s;
  logic                  halt_hit_s;
  logic [31:0]           ld_addr_al_s;
  logic [DEPTH_LOG2-1:0] ld_idx_s;

  // Valid bits are two-state so unwritten words read as FILL_WORD from time zero.
  logic [31:0]           mem_r [DEPTH];
  bit   [DEPTH-1:0]      valid_r;

  assign data        = data_r;
  assign ready       = ready_r;
  assign fetch_count = fetch_count_r;
  assign halted      = halted_r;
  assign misaligned  = misaligned_r;

  // Handshake FSM next-state: accept in IDLE, count down wait states, one-cycle RESP.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    accept_s       = 1'b0;
    enter_resp_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          accept_s = 1'b1;
          if (WAIT_INIT == 8'd0) begin
            state_nxt_s  = ST_RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_nxt_s    = ST_WAIT;
            wait_cnt_nxt_s = WAIT_INIT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r <= 8'd1) begin
          state_nxt_s    = ST_RESP;
          wait_cnt_nxt_s = 8'd0;
          enter_resp_s   = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r - 8'd1;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Read path; with no wait states RESP is entered on the accept edge, so use the live address.
  always_comb begin
    rd_addr_s = 32'h0000_0000;
    if (state_r == ST_IDLE) begin
      rd_addr_s = addr & 32'hFFFF_FFFC;
    end else begin
      rd_addr_s = addr_r;
    end
    rd_idx_s = word_idx(rd_addr_s);
    if (in_range(rd_addr_s) && valid_r[rd_idx_s]) begin
      rd_word_s = mem_r[rd_idx_s];
    end else begin
      rd_word_s = FILL_WORD;
    end
    halt_hit_s = (rd_word_s == HALT_WORD) && last_valid_r &&
                 (last_addr_r == rd_addr_s) && (last_word_r == HALT_WORD);
    ld_addr_al_s = ld_addr & 32'hFFFF_FFFC;
    ld_idx_s     = word_idx(ld_addr_al_s);
  end

  // Control, response and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= 8'd0;
      addr_r        <= 32'h0000_0000;
      data_r        <= 32'h0000_0000;
      ready_r       <= 1'b0;
      fetch_count_r <= 32'h0000_0000;
      halted_r      <= 1'b0;
      misaligned_r  <= 1'b0;
      last_valid_r  <= 1'b0;
      last_addr_r   <= 32'h0000_0000;
      last_word_r   <= 32'h0000_0000;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      ready_r    <= enter_resp_s;
      if (accept_s) begin
        addr_r <= addr & 32'hFFFF_FFFC;
        if (addr[1:0] != 2'b00) begin
          misaligned_r <= 1'b1;
        end
      end
      if (enter_resp_s) begin
        data_r <= rd_word_s;
        if (fetch_count_r != 32'hFFFF_FFFF) begin
          fetch_count_r <= fetch_count_r + 32'd1;
        end
        if (halt_hit_s) begin
          halted_r <= 1'b1;
        end
        last_valid_r <= 1'b1;
        last_addr_r  <= rd_addr_s;
        last_word_r  <= rd_word_s;
      end
    end
  end

  // Preload port; deliberately independent of rst so contents survive reset.
  always_ff @(posedge clk) begin
    if (ld_en && in_range(ld_addr_al_s)) begin
      mem_r[ld_idx_s]   <= ld_data;
      valid_r[ld_idx_s] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_mem_model.sv
// Directed bench for instr_mem_model: four instances cover wait states, base offset,
// halt/misalignment flags and reset abort.
module tb_instr_mem_model;

  localparam logic [31:0] FILL = 32'h2421_0001;
  localparam logic [31:0] HALT = 32'h1000_FFFF;

  logic             clk;
  logic [3:0]       rst_v;
  logic [3:0]       req_v;
  logic [3:0]       ld_en_v;
  logic [3:0][31:0] addr_v;
  logic [3:0][31:0] ld_addr_v;
  logic [3:0][31:0] ld_data_v;
  logic [3:0][31:0] data_v;
  logic [3:0][31:0] count_v;
  logic [3:0]       ready_v;
  logic [3:0]       halted_v;
  logic [3:0]       mis_v;

  int checks = 0;
  int errors = 0;

  instr_mem_model u0 (
    .clk(clk), .rst(rst_v[0]), .req(req_v[0]), .addr(addr_v[0]), .data(data_v[0]),
    .ready(ready_v[0]), .ld_en(ld_en_v[0]), .ld_addr(ld_addr_v[0]), .ld_data(ld_data_v[0]),
    .fetch_count(count_v[0]), .halted(halted_v[0]), .misaligned(mis_v[0]));

  instr_mem_model #(.WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst(rst_v[1]), .req(req_v[1]), .addr(addr_v[1]), .data(data_v[1]),
    .ready(ready_v[1]), .ld_en(ld_en_v[1]), .ld_addr(ld_addr_v[1]), .ld_data(ld_data_v[1]),
    .fetch_count(count_v[1]), .halted(halted_v[1]), .misaligned(mis_v[1]));

  instr_mem_model #(.BASE_ADDR(32'h8000_0000)) u2 (
    .clk(clk), .rst(rst_v[2]), .req(req_v[2]), .addr(addr_v[2]), .data(data_v[2]),
    .ready(ready_v[2]), .ld_en(ld_en_v[2]), .ld_addr(ld_addr_v[2]), .ld_data(ld_data_v[2]),
    .fetch_count(count_v[2]), .halted(halted_v[2]), .misaligned(mis_v[2]));

  instr_mem_model #(.WAIT_CYCLES(5)) u3 (
    .clk(clk), .rst(rst_v[3]), .req(req_v[3]), .addr(addr_v[3]), .data(data_v[3]),
    .ready(ready_v[3]), .ld_en(ld_en_v[3]), .ld_addr(ld_addr_v[3]), .ld_data(ld_data_v[3]),
    .fetch_count(count_v[3]), .halted(halted_v[3]), .misaligned(mis_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  // Starts at a negedge with the instance idle; returns cyc=-1 if ready never comes.
  task automatic fetch(input int u, input logic [31:0] a, output logic [31:0] d, output int cyc);
    req_v[u]  = 1'b1;
    addr_v[u] = a;
    cyc = -1;
    d   = 32'h0000_0000;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ready_v[u]) begin
        cyc = i;
        d   = data_v[u];
        break;
      end
    end
    req_v[u] = 1'b0;
    @(negedge clk);
  endtask

  task automatic load(input int u, input logic [31:0] a, input logic [31:0] d);
    ld_en_v[u]   = 1'b1;
    ld_addr_v[u] = a;
    ld_data_v[u] = d;
    @(negedge clk);
    ld_en_v[u] = 1'b0;
  endtask

  task automatic test_reset();
    for (int u = 0; u < 4; u++) begin
      checks++;
      if (ready_v[u] !== 1'b0 || data_v[u] !== 32'h0 || count_v[u] !== 32'h0 ||
          halted_v[u] !== 1'b0 || mis_v[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state u%0d: got rdy=%b data=%h cnt=%0d halt=%b mis=%b expected all zero",
                 u, ready_v[u], data_v[u], count_v[u], halted_v[u], mis_v[u]);
      end
    end
  endtask

  task automatic test_fill_stream();
    logic exp_rdy;
    req_v[0]  = 1'b1;
    addr_v[0] = 32'h0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      exp_rdy = (i % 2) == 1;
      checks++;
      if (ready_v[0] !== exp_rdy || (exp_rdy && data_v[0] !== FILL)) begin
        errors++;
        $display("FAIL fill_stream cycle %0d: got rdy=%b data=%h expected rdy=%b data=%h",
                 i, ready_v[0], data_v[0], exp_rdy, FILL);
      end
    end
    req_v[0] = 1'b0;
    checks++;
    if (count_v[0] !== 32'd3) begin
      errors++;
      $display("FAIL fill_count: got %0d expected 3", count_v[0]);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] d;
    int cyc;
    ld_en_v[0] = 1'b1; ld_addr_v[0] = 32'h30; ld_data_v[0] = 32'h5555_AAAA;
    req_v[0] = 1'b1; addr_v[0] = 32'h30;
    @(negedge clk);
    ld_en_v[0] = 1'b0;
    req_v[0]   = 1'b0;
    checks++;
    if (ready_v[0] !== 1'b1 || data_v[0] !== FILL) begin
      errors++;
      $display("FAIL same_edge_old: got rdy=%b data=%h expected rdy=1 data=%h", ready_v[0], data_v[0], FILL);
    end
    @(negedge clk);
    fetch(0, 32'h30, d, cyc);
    checks++;
    if (d !== 32'h5555_AAAA || cyc !== 1) begin
      errors++;
      $display("FAIL same_edge_new: got data=%h lat=%0d expected data=5555aaaa lat=1", d, cyc);
    end
  endtask

  task automatic test_wait3();
    logic [31:0] d;
    int cyc;
    logic exp_rdy;
    load(1, 32'h10, 32'hDEAD_BEEF);
    fetch(1, 32'h10, d, cyc);
    checks++;
    if (d !== 32'hDEAD_BEEF || cyc !== 4) begin
      errors++;
      $display("FAIL wait3_fetch: got data=%h lat=%0d expected data=deadbeef lat=4", d, cyc);
    end
    checks++;
    if (ready_v[1] !== 1'b0 || data_v[1] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wait3_hold: got rdy=%b data=%h expected rdy=0 data=deadbeef", ready_v[1], data_v[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    req_v[1]  = 1'b1;
    addr_v[1] = 32'h10;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      exp_rdy = (i == 4) || (i == 9) || (i == 14);
      checks++;
      if (ready_v[1] !== exp_rdy) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got rdy=%b expected %b", i, ready_v[1], exp_rdy);
      end
    end
    req_v[1] = 1'b0;
    checks++;
    if (count_v[1] !== 32'd4) begin
      errors++;
      $display("FAIL back_to_back_count: got %0d expected 4", count_v[1]);
    end
  endtask

  task automatic test_range();
    logic [31:0] d;
    int cyc;
    load(2, 32'h8000_0FFC, 32'hCAFE_F00D);
    load(2, 32'h7FFF_FFFC, 32'h1111_1111);
    load(2, 32'h8000_1000, 32'h2222_2222);
    fetch(2, 32'h7FFF_FFFC, d, cyc);
    checks++;
    if (d !== FILL) begin errors++; $display("FAIL range_below: got %h expected %h", d, FILL); end
    fetch(2, 32'h8000_1000, d, cyc);
    checks++;
    if (d !== FILL) begin errors++; $display("FAIL range_above: got %h expected %h", d, FILL); end
    fetch(2, 32'h8000_0FFC, d, cyc);
    checks++;
    if (d !== 32'hCAFE_F00D) begin errors++; $display("FAIL range_last: got %h expected cafef00d", d); end
    fetch(2, 32'h8000_0000, d, cyc);
    checks++;
    if (d !== FILL) begin errors++; $display("FAIL range_first: got %h expected %h", d, FILL); end
  endtask

  task automatic test_misaligned();
    logic [31:0] d;
    int cyc;
    checks++;
    if (mis_v[0] !== 1'b0) begin errors++; $display("FAIL mis_initial: got %b expected 0", mis_v[0]); end
    load(0, 32'h10, 32'h1234_5678);
    fetch(0, 32'h13, d, cyc);
    checks++;
    if (d !== 32'h1234_5678 || mis_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL mis_fetch: got data=%h mis=%b expected data=12345678 mis=1", d, mis_v[0]);
    end
    fetch(0, 32'h18, d, cyc);
    checks++;
    if (d !== FILL || mis_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL mis_sticky: got data=%h mis=%b expected data=%h mis=1", d, mis_v[0], FILL);
    end
    rst_v[0] = 1'b1;
    @(negedge clk);
    rst_v[0] = 1'b0;
    checks++;
    if (mis_v[0] !== 1'b0 || count_v[0] !== 32'd0 || data_v[0] !== 32'd0) begin
      errors++;
      $display("FAIL mis_reset: got mis=%b cnt=%0d data=%h expected 0 0 0", mis_v[0], count_v[0], data_v[0]);
    end
    fetch(0, 32'h10, d, cyc);
    checks++;
    if (d !== 32'h1234_5678 || mis_v[0] !== 1'b0 || cyc !== 1) begin
      errors++;
      $display("FAIL mis_after_reset: got data=%h mis=%b lat=%0d expected 12345678 0 1", d, mis_v[0], cyc);
    end
  endtask

  task automatic test_halt();
    logic [31:0] d;
    int cyc;
    logic [31:0] seq_addr [5];
    logic        seq_halt [5];
    seq_addr = '{32'h20, 32'h24, 32'h20, 32'h20, 32'h24};
    seq_halt = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    load(0, 32'h20, HALT);
    load(0, 32'h24, HALT);
    for (int i = 0; i < 5; i++) begin
      fetch(0, seq_addr[i], d, cyc);
      checks++;
      if (d !== HALT || halted_v[0] !== seq_halt[i]) begin
        errors++;
        $display("FAIL halt step %0d: got data=%h halted=%b expected data=%h halted=%b",
                 i, d, halted_v[0], HALT, seq_halt[i]);
      end
    end
  endtask

  task automatic test_wait_abort();
    logic [31:0] d;
    int cyc;
    int seen;
    load(3, 32'h8, 32'hA5A5_5A5A);
    req_v[3]  = 1'b1;
    addr_v[3] = 32'h8;
    seen = 0;
    @(negedge clk);
    @(negedge clk);
    if (ready_v[3]) seen++;
    rst_v[3] = 1'b1;
    req_v[3] = 1'b0;
    ld_en_v[3] = 1'b1; ld_addr_v[3] = 32'hC; ld_data_v[3] = 32'h0BAD_CAFE;
    @(negedge clk);
    rst_v[3]   = 1'b0;
    ld_en_v[3] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready_v[3]) seen++;
    end
    checks++;
    if (seen !== 0 || count_v[3] !== 32'd0) begin
      errors++;
      $display("FAIL abort_no_ready: got pulses=%0d cnt=%0d expected 0 0", seen, count_v[3]);
    end
    fetch(3, 32'h8, d, cyc);
    checks++;
    if (d !== 32'hA5A5_5A5A || cyc !== 6) begin
      errors++;
      $display("FAIL abort_refetch: got data=%h lat=%0d expected a5a55a5a 6", d, cyc);
    end
    fetch(3, 32'hC, d, cyc);
    checks++;
    if (d !== 32'h0BAD_CAFE || count_v[3] !== 32'd2) begin
      errors++;
      $display("FAIL abort_load_in_reset: got data=%h cnt=%0d expected 0badcafe 2", d, count_v[3]);
    end
  endtask

  initial begin
    rst_v = 4'hF; req_v = 4'h0; ld_en_v = 4'h0;
    addr_v = '0; ld_addr_v = '0; ld_data_v = '0;
    repeat (2) @(negedge clk);
    rst_v = 4'h0;
    test_reset();
    test_fill_stream();
    test_same_edge();
    test_wait3();
    test_back_to_back();
    test_range();
    test_misaligned();
    test_halt();
    test_wait_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
